// File: rtl/mips_main_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : mips_main_fsm
//  Purpose  : Multicycle MIPS control unit. Moore main FSM, ALU decoder,
//             PC-enable logic and memory-ready handshake with timeout.
//  Revision : 1.0  initial release
// ============================================================================
module mips_main_fsm #(
  parameter int TO_W        = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_control,
  output logic       pc_en,
  output logic       illegal_op,
  output logic       bus_error
);

  // State encoding
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_ADDIEX   = 4'd9;
  localparam logic [3:0] S_ADDIWB   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_HALT     = 4'd12;

  // Supported opcodes
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [TO_W-1:0] CNT_MAX      = '1;
  localparam logic [TO_W-1:0] TIMEOUT_LAST = TO_W'(MEM_TIMEOUT - 1);

  logic [3:0]      state;
  logic [3:0]      state_next;
  logic [TO_W-1:0] wait_cnt;
  logic [TO_W-1:0] wait_cnt_next;
  logic            set_illegal;
  logic            set_bus;
  logic            in_mem_state;
  logic            timeout;
  logic            funct_ok;
  logic [2:0]      funct_ctrl;
  logic [1:0]      alu_op;
  logic            pc_write;
  logic            branch;

  // A memory access is outstanding in these three states only; mem_ready is
  // meaningless anywhere else.
  assign in_mem_state = (state == S_FETCH) || (state == S_MEMREAD) ||
                        (state == S_MEMWRITE);
  assign timeout      = in_mem_state && !mem_ready && (wait_cnt == TIMEOUT_LAST);

  // R-type funct decode; funct_ok drops for any unsupported function code
  always_comb begin
    funct_ok   = 1'b1;
    funct_ctrl = 3'b010;
    case (funct)
      6'b100000: funct_ctrl = 3'b010;
      6'b100010: funct_ctrl = 3'b110;
      6'b100100: funct_ctrl = 3'b000;
      6'b100101: funct_ctrl = 3'b001;
      6'b101010: funct_ctrl = 3'b111;
      default: begin
        funct_ok   = 1'b0;
        funct_ctrl = 3'b010;
      end
    endcase
  end

  // Next-state logic; a memory timeout overrides any normal transition
  always_comb begin
    state_next  = state;
    set_illegal = 1'b0;
    set_bus     = 1'b0;
    case (state)
      S_FETCH:    if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECUTE;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default: begin
            state_next  = S_HALT;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR:   state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
      S_EXECUTE: begin
        if (funct_ok) begin
          state_next = S_ALUWB;
        end else begin
          state_next  = S_HALT;
          set_illegal = 1'b1;
        end
      end
      S_ALUWB:    state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      S_ADDIEX:   state_next = S_ADDIWB;
      S_ADDIWB:   state_next = S_FETCH;
      S_JUMP:     state_next = S_FETCH;
      S_HALT:     state_next = S_HALT;
      default:    state_next = S_FETCH;
    endcase
    if (timeout) begin
      state_next = S_HALT;
      set_bus    = 1'b1;
    end
  end

  // Wait counter counts stalled memory cycles; any other cycle clears it, so
  // it is always zero on entry to a memory state.
  always_comb begin
    wait_cnt_next = '0;
    if (in_mem_state && !mem_ready) begin
      wait_cnt_next = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + TO_W'(1);
    end
  end

  // Moore control decode; strobes are qualified by mem_ready and gated by reset
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    pc_src     = 2'd0;
    alu_op     = 2'b00;
    pc_write   = 1'b0;
    branch     = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:   alu_src_b = 2'd3;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        i_or_d    = 1'b1;
        mem_write = mem_ready;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'd1;
        branch    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      S_ADDIWB:   reg_write = 1'b1;
      S_JUMP: begin
        pc_src   = 2'd2;
        pc_write = 1'b1;
      end
      default: ;
    endcase

    case (alu_op)
      2'b01:   alu_control = 3'b110;
      2'b10:   alu_control = funct_ctrl;
      default: alu_control = 3'b010;
    endcase

    if (!reset) begin
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      pc_write  = 1'b0;
      branch    = 1'b0;
    end
    pc_en = pc_write | (branch & zero);
  end

  // State, wait counter and sticky error flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_FETCH;
      wait_cnt   <= '0;
      illegal_op <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (set_illegal) illegal_op <= 1'b1;
      if (set_bus)     bus_error  <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_main_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_main_fsm
//  Purpose  : Scoreboard bench for mips_main_fsm. The stimulus process pushes
//             the expected control vector for each cycle; a monitor pops and
//             compares it at the falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mips_main_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, i_or_d, ir_write, reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a, pc_en, illegal_op, bus_error;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;

  mips_main_fsm #(.TO_W(8), .MEM_TIMEOUT(200)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .i_or_d(i_or_d), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_control(alu_control),
    .pc_en(pc_en), .illegal_op(illegal_op), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [17:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  int        n_checks = 0;
  int        n_errors = 0;
  logic      exp_ill  = 1'b0;
  logic      exp_bus  = 1'b0;

  // Hand-computed control vectors (flag bits left 0, added at push time)
  logic [17:0] E_FETCH_WAIT, E_FETCH_RDY, E_DECODE, E_MEMADR, E_MEMREAD, E_MEMWB;
  logic [17:0] E_MEMW_WAIT, E_MEMW_RDY, E_ALUWB, E_BR_TAKEN, E_BR_NOT;
  logic [17:0] E_ADDIEX, E_ADDIWB, E_JUMP, E_HALT;

  function automatic logic [17:0] v(input logic mr, mw, iod, irw, rd, m2r, rw, asa,
                                    input logic [1:0] asb, ps,
                                    input logic [2:0] ac, input logic pe);
    return {mr, mw, iod, irw, rd, m2r, rw, asa, asb, ps, ac, pe, 2'b00};
  endfunction

  function automatic logic [17:0] exec_vec(input logic [2:0] ac);
    return v(0,0,0,0,0,0,0,1, 2'd0, 2'd0, ac, 0);
  endfunction

  // Drive one cycle of inputs and push the expected response for it
  task automatic step(input logic rst, input logic rdy, input logic z,
                      input logic [17:0] exp, input string name);
    sb_entry_t e;
    reset     = rst;
    mem_ready = rdy;
    zero      = z;
    e.name    = name;
    e.exp     = exp | {16'b0, exp_ill, exp_bus};
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare whatever the DUT presents against the oldest expectation
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_entry_t e;
      logic [17:0] act;
      e   = sb.pop_front();
      act = {mem_req, mem_write, i_or_d, ir_write, reg_dst, mem_to_reg, reg_write,
             alu_src_a, alu_src_b, pc_src, alu_control, pc_en, illegal_op, bus_error};
      n_checks++;
      if (act !== e.exp) begin
        n_errors++;
        $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [5:0] rf [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [2:0] rc [5] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111};

  initial begin
    E_FETCH_WAIT = v(1,0,0,0,0,0,0,0, 2'd1, 2'd0, 3'b010, 0);
    E_FETCH_RDY  = v(1,0,0,1,0,0,0,0, 2'd1, 2'd0, 3'b010, 1);
    E_DECODE     = v(0,0,0,0,0,0,0,0, 2'd3, 2'd0, 3'b010, 0);
    E_MEMADR     = v(0,0,0,0,0,0,0,1, 2'd2, 2'd0, 3'b010, 0);
    E_MEMREAD    = v(1,0,1,0,0,0,0,0, 2'd0, 2'd0, 3'b010, 0);
    E_MEMWB      = v(0,0,0,0,0,1,1,0, 2'd0, 2'd0, 3'b010, 0);
    E_MEMW_WAIT  = v(1,0,1,0,0,0,0,0, 2'd0, 2'd0, 3'b010, 0);
    E_MEMW_RDY   = v(1,1,1,0,0,0,0,0, 2'd0, 2'd0, 3'b010, 0);
    E_ALUWB      = v(0,0,0,0,1,0,1,0, 2'd0, 2'd0, 3'b010, 0);
    E_BR_TAKEN   = v(0,0,0,0,0,0,0,1, 2'd0, 2'd1, 3'b110, 1);
    E_BR_NOT     = v(0,0,0,0,0,0,0,1, 2'd0, 2'd1, 3'b110, 0);
    E_ADDIEX     = v(0,0,0,0,0,0,0,1, 2'd2, 2'd0, 3'b010, 0);
    E_ADDIWB     = v(0,0,0,0,0,0,1,0, 2'd0, 2'd0, 3'b010, 0);
    E_JUMP       = v(0,0,0,0,0,0,0,0, 2'd0, 2'd2, 3'b010, 1);
    E_HALT       = v(0,0,0,0,0,0,0,0, 2'd0, 2'd0, 3'b010, 0);

    reset = 1'b0; mem_ready = 1'b0; zero = 1'b0; op = 6'd0; funct = 6'd0;
    @(posedge clk);
    #1;
    // Reset held low: FETCH, but mem_ready=1 must not raise any write enable
    step(0, 1, 1, E_FETCH_WAIT, "reset_gates_enables");
    step(0, 1, 1, E_FETCH_WAIT, "reset_gates_enables2");

    // lw with mem_ready always high: 5 cycles
    op = 6'b100011;
    step(1, 1, 0, E_FETCH_RDY, "lw_fetch");
    step(1, 1, 0, E_DECODE,    "lw_decode");
    step(1, 1, 0, E_MEMADR,    "lw_memadr");
    step(1, 1, 0, E_MEMREAD,   "lw_memread");
    step(1, 1, 0, E_MEMWB,     "lw_memwb");

    // R-type, each supported funct: 4 cycles
    op = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      funct = rf[i];
      step(1, 1, 0, E_FETCH_RDY,     "r_fetch");
      step(1, 1, 0, E_DECODE,        "r_decode");
      step(1, 1, 0, exec_vec(rc[i]), "r_execute");
      step(1, 1, 0, E_ALUWB,         "r_aluwb");
    end

    // beq taken then not taken
    op = 6'b000100;
    step(1, 1, 1, E_FETCH_RDY, "beq_t_fetch");
    step(1, 1, 1, E_DECODE,    "beq_t_decode");
    step(1, 1, 1, E_BR_TAKEN,  "beq_taken");
    step(1, 1, 0, E_FETCH_RDY, "beq_n_fetch");
    step(1, 1, 0, E_DECODE,    "beq_n_decode");
    step(1, 1, 0, E_BR_NOT,    "beq_not_taken");

    // addi
    op = 6'b001000;
    step(1, 1, 0, E_FETCH_RDY, "addi_fetch");
    step(1, 1, 0, E_DECODE,    "addi_decode");
    step(1, 1, 0, E_ADDIEX,    "addi_ex");
    step(1, 1, 0, E_ADDIWB,    "addi_wb");

    // j
    op = 6'b000010;
    step(1, 1, 0, E_FETCH_RDY, "j_fetch");
    step(1, 1, 0, E_DECODE,    "j_decode");
    step(1, 1, 0, E_JUMP,      "j_jump");

    // sw with two fetch wait states and three write wait states
    op = 6'b101011;
    step(1, 0, 0, E_FETCH_WAIT, "sw_fetch_wait");
    step(1, 0, 0, E_FETCH_WAIT, "sw_fetch_wait");
    step(1, 1, 0, E_FETCH_RDY,  "sw_fetch");
    step(1, 0, 0, E_DECODE,     "sw_decode");
    step(1, 0, 0, E_MEMADR,     "sw_memadr");
    for (int i = 0; i < 3; i++) step(1, 0, 0, E_MEMW_WAIT, "sw_write_wait");
    step(1, 1, 0, E_MEMW_RDY,   "sw_write");
    step(1, 0, 0, E_FETCH_WAIT, "sw_back_to_fetch");

    // reset asserted mid-MEMREAD: returns to FETCH, MEMWB never reached
    op = 6'b100011;
    step(1, 1, 0, E_FETCH_RDY,  "lwr_fetch");
    step(1, 1, 0, E_DECODE,     "lwr_decode");
    step(1, 1, 0, E_MEMADR,     "lwr_memadr");
    step(1, 0, 0, E_MEMREAD,    "lwr_memread_wait");
    step(0, 1, 0, E_MEMREAD,    "lwr_memread_reset");
    step(1, 0, 0, E_FETCH_WAIT, "lwr_after_reset");
    step(1, 0, 0, E_FETCH_WAIT, "lwr_after_reset2");

    // Illegal opcode
    op = 6'b111111;
    step(1, 1, 0, E_FETCH_RDY, "ill_fetch");
    step(1, 1, 0, E_DECODE,    "ill_decode");
    exp_ill = 1'b1;
    step(1, 1, 1, E_HALT,      "ill_halt");
    step(1, 1, 1, E_HALT,      "ill_halt_stays");
    step(0, 1, 0, E_HALT,      "ill_reset");
    exp_ill = 1'b0;
    step(1, 0, 0, E_FETCH_WAIT, "ill_cleared");

    // Unsupported R-type funct: no ALUWB
    op = 6'b000000; funct = 6'b000000;
    step(1, 1, 0, E_FETCH_RDY,         "badf_fetch");
    step(1, 1, 0, E_DECODE,            "badf_decode");
    step(1, 1, 0, exec_vec(3'b010),    "badf_execute");
    exp_ill = 1'b1;
    step(1, 1, 0, E_HALT,              "badf_halt");
    step(0, 0, 0, E_HALT,              "badf_reset");
    exp_ill = 1'b0;

    // Fetch timeout: 200 stalled cycles, then HALT with bus_error
    for (int i = 0; i < 200; i++) step(1, 0, 0, E_FETCH_WAIT, "to_fetch_wait");
    exp_bus = 1'b1;
    step(1, 1, 0, E_HALT,      "to_halt");
    step(1, 1, 0, E_HALT,      "to_halt_stays");
    step(0, 0, 0, E_HALT,      "to_reset");
    exp_bus = 1'b0;
    step(1, 1, 0, E_FETCH_RDY, "to_recovered");

    @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
